// File: rtl/codebook_fetcher_if.sv
// Burst-read memory port used by the codebook fetcher: one request at a time,
// waitrequest backpressure, and read data returned with a valid strobe.
interface codebook_fetcher_if #(
  parameter int ADDR_W = 22
) ();
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [8:0]        mem_burstcnt;
  logic              mem_wait;
  logic [63:0]       mem_din;
  logic              mem_din_valid;

  modport master (
    output mem_rd, mem_addr, mem_burstcnt,
    input  mem_wait, mem_din, mem_din_valid
  );

  modport slave (
    input  mem_rd, mem_addr, mem_burstcnt,
    output mem_wait, mem_din, mem_din_valid
  );
endinterface

// File: rtl/codebook_fetcher.sv
// Streams a 256-word codebook into the cache as BURST_LEN-word memory bursts.
// Optional macro CB_FETCH_CHECK_EN adds a sticky cache-index mismatch flag.
//
// state     | meaning
// IDLE      | waiting for codebook_wait with ram_read_offset = 0
// REQ       | mem_rd held until the memory accepts the burst
// DATA      | collecting beats of the outstanding burst, forwarding to the cache
// WAIT_DROP | all 256 words delivered, waiting for codebook_wait to fall
// DRAIN     | fill aborted, swallowing the rest of the outstanding burst
module codebook_fetcher #(
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 22
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              codebook_wait,
  input  logic [7:0]        ram_read_offset,
  input  logic [ADDR_W-1:0] cb_base_addr,
  output logic              vram_valid,
  output logic [63:0]       cache_din,
  output logic              cb_offset_err,
  codebook_fetcher_if.master mem
);

  localparam int         LOG_BL  = $clog2(BURST_LEN);
  localparam logic [8:0] BL_MASK = 9'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    DATA,
    WAIT_DROP,
    DRAIN
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        burst_idx;
  logic [8:0]        beat_cnt;
  logic [8:0]        beat_nxt;
  logic              abort_q;
  logic              start;
  logic              beat_take;
  logic              burst_end;
  logic              deliver;

  assign beat_nxt  = beat_cnt + 9'd1;
  assign beat_take = mem.mem_din_valid && ((state == DATA) || (state == DRAIN));
  // Bursts are aligned to the fill start, so the low bits of the running count mark a burst boundary.
  assign burst_end = beat_take && ((beat_nxt & BL_MASK) == 9'd0);
  assign deliver   = (state == DATA) && mem.mem_din_valid && codebook_wait;

  assign mem.mem_rd       = (state == REQ);
  assign mem.mem_addr     = base_q + (ADDR_W'(burst_idx) << LOG_BL);
  assign mem.mem_burstcnt = 9'(BURST_LEN);

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (codebook_wait && (ram_read_offset == 8'd0)) begin
          state_nxt = REQ;
          start     = 1'b1;
        end
      end
      REQ: begin
        // An abort seen while waiting still lets the request complete, then drains it.
        if (!mem.mem_wait) state_nxt = (codebook_wait && !abort_q) ? DATA : DRAIN;
      end
      DATA: begin
        if (!codebook_wait) state_nxt = burst_end ? IDLE : DRAIN;
        else if (burst_end) state_nxt = beat_nxt[8] ? WAIT_DROP : REQ;
      end
      DRAIN: begin
        if (burst_end) state_nxt = IDLE;
      end
      WAIT_DROP: begin
        if (!codebook_wait) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      base_q     <= '0;
      burst_idx  <= '0;
      beat_cnt   <= '0;
      abort_q    <= 1'b0;
      vram_valid <= 1'b0;
      cache_din  <= '0;
    end else begin
      state      <= state_nxt;
      vram_valid <= deliver;
      if (deliver) cache_din <= mem.mem_din;
      if (start) begin
        base_q    <= cb_base_addr;
        burst_idx <= '0;
        beat_cnt  <= '0;
        abort_q   <= 1'b0;
      end else begin
        if (beat_take) beat_cnt <= beat_nxt;
        if ((state == DATA) && (state_nxt == REQ)) burst_idx <= burst_idx + 8'd1;
        if ((state == REQ) && !codebook_wait) abort_q <= 1'b1;
      end
    end
  end

`ifdef CB_FETCH_CHECK_EN
  logic [7:0] exp_idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_idx       <= '0;
      cb_offset_err <= 1'b0;
    end else begin
      if (start) exp_idx <= '0;
      else if (vram_valid) exp_idx <= exp_idx + 8'd1;
      if (vram_valid && (ram_read_offset != exp_idx)) cb_offset_err <= 1'b1;
    end
  end
`else
  assign cb_offset_err = 1'b0;
`endif

endmodule

// File: doc/codebook_fetcher.md
CODEBOOK_FETCHER -- requirements
Module: codebook_fetcher

Interface
REQ-001 Parameter BURST_LEN, default 8: 64-bit words per memory read burst; power of two, 1..256.
REQ-002 Parameter ADDR_W, default 22: width of the 64-bit-word memory address.
REQ-003 Port clock, input, 1: single clock for all logic.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port codebook_wait, input, 1: the cache is requesting a 256-word codebook fill.
REQ-006 Port ram_read_offset, input, 8: the cache's current word index within the codebook.
REQ-007 Port cb_base_addr, input, ADDR_W: word address of codebook word 0; sampled at fetch start.
REQ-008 Port vram_valid, output, 1: one codebook word is presented on cache_din this cycle.
REQ-009 Port cache_din, output, 64: codebook word delivered to the cache.
REQ-010 Port mem_rd, output, 1: burst read request.
REQ-011 Port mem_addr, output, ADDR_W: burst start word address.
REQ-012 Port mem_burstcnt, output, 9: burst length; constant BURST_LEN.
REQ-013 Port mem_wait, input, 1: memory waitrequest.
REQ-014 Port mem_din, input, 64: memory read data.
REQ-015 Port mem_din_valid, input, 1: memory read data is valid.
REQ-016 Port cb_offset_err, output, 1: sticky offset-mismatch flag (see Configuration).

Function
REQ-017 FSM states: IDLE, REQ, DATA, WAIT_DROP, DRAIN.
REQ-018 IDLE->REQ when codebook_wait=1 and ram_read_offset=0; at that transition latch cb_base_addr, and clear burst_idx and beat_cnt.
REQ-019 REQ: hold mem_rd=1 and mem_addr=base+burst_idx*BURST_LEN (modulo 2^ADDR_W) until the first cycle with mem_wait=0, then go to DATA.
REQ-020 DATA: each mem_din_valid beat increments beat_cnt (9 bits). When BURST_LEN beats have arrived for the burst: if beat_cnt=256, go to WAIT_DROP; otherwise increment burst_idx and go to REQ.
REQ-021 Only one burst is outstanding at a time; mem_rd=0 in every state except REQ.
REQ-022 The cycle after each mem_din_valid beat in DATA, vram_valid=1 and cache_din=registered mem_din; latency is exactly 1 cycle.
REQ-023 WAIT_DROP: go to IDLE on the first cycle with codebook_wait=0; a fill is never restarted before codebook_wait has dropped.
REQ-024 Abort: if codebook_wait=0 in REQ or DATA with beat_cnt<256, go to DRAIN.
REQ-025 Abort from REQ while mem_wait=1: hold the request until it is accepted, then drain that burst.
REQ-026 DRAIN: consume the remaining beats of the outstanding burst with vram_valid suppressed, then go to IDLE; issue no new bursts.
REQ-027 A start condition seen in DRAIN or WAIT_DROP is ignored until IDLE is reached.
REQ-028 mem_din_valid in IDLE or WAIT_DROP is discarded and never produces vram_valid.

Reset
REQ-029 On reset_n=0 the block SHALL asynchronously enter IDLE, with vram_valid=0, cache_din=0, mem_rd=0, mem_addr=0, cb_offset_err=0, and all counters cleared.
REQ-030 Reset mid-burst SHALL abandon the burst with no drain; any beats arriving after reset are handled per REQ-028.

Configuration
REQ-031 Macro CB_FETCH_CHECK_EN defined: on each vram_valid cycle, compare ram_read_offset with the expected index (delivered-beat count mod 256). On mismatch, set cb_offset_err; it stays set until reset.
REQ-032 Macro CB_FETCH_CHECK_EN undefined: cb_offset_err is tied to 0 and no compare logic is built.

Verification
REQ-033 Full fill, no waitstates: base=0x1000, BURST_LEN=8. Required: 32 bursts at addresses 0x1000, 0x1008 … 0x10F8; 256 vram_valid pulses with data in order; then WAIT_DROP->IDLE.
REQ-034 Backpressure: mem_wait=1 for 5 cycles on burst 3. Required: mem_rd and mem_addr=0x1018 held stable for those 5 cycles; no lost or duplicated words.
REQ-035 Abort: codebook_wait drops after 100 beats, during burst 12. Required: remaining 4 beats drained with vram_valid=0; no burst at 0x1068; IDLE reached.
REQ-036 Address wrap: base=0x3FFFF8, ADDR_W=22. Required: second burst at 0x000000.
REQ-037 Async reset asserted mid-DATA. Required: mem_rd=0 and vram_valid=0 immediately; stray beats ignored; next fill starts cleanly.
REQ-038 With CB_FETCH_CHECK_EN: force ram_read_offset=5 at beat 4. Required: cb_offset_err=1 and sticky; without the macro it stays 0.
